// File: rtl/armleobus_wait_responder.sv
// rtl/armleobus_wait_responder.sv - memory-backed armleobus responder with programmable wait states
//
// Purpose:
//   Answers armleobus read/write transactions from a word-organised scratch
//   memory. Each transaction waits WAIT_CYCLES idle cycles before its first
//   beat. Bursts of up to 15 beats then follow back to back. A mandatory
//   one-cycle gap separates transactions.
//
//   Errors are decided once, when the request is latched, and apply to every
//   beat. The error checks, in priority order, are:
//     - unknown command or misaligned address -> INVALID_OPERATION
//     - address above the memory              -> UNKNOWN_ADDRESS
//   Erroring beats never write and return rdata = 0.
//
// Optional feature (macro ARMLEOBUS_RESP_JITTER_EN):
//   A 16-bit Galois LFSR (taps 16,14,13,11, seed 16'hACE1) advances every
//   cycle. The initial wait of each transaction becomes
//   WAIT_CYCLES + lfsr[1:0], sampled when the request is latched.
//
// Ports:
//   clk                  in   clock, rising edge
//   rst_n                in   asynchronous active-low reset
//   transaction          in   request, held until the last beat's done
//   cmd[2:0]             in   READ / WRITE, anything else is invalid
//   address[33:0]        in   byte address of beat 0
//   burstcount[3:0]      in   beats in the transaction (0 means 1)
//   wdata[31:0]          in   write data for the current beat
//   wbyte_enable[3:0]    in   per-byte write enable
//   transaction_done     out  one-cycle pulse per beat
//   transaction_response out  response code, valid with transaction_done
//   rdata[31:0]          out  read data, valid with transaction_done on reads

module armleobus_wait_responder #(
  parameter int DEPTH_LOG2  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        transaction,
  input  logic [2:0]  cmd,
  input  logic [33:0] address,
  input  logic [3:0]  burstcount,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbyte_enable,
  output logic        transaction_done,
  output logic [2:0]  transaction_response,
  output logic [31:0] rdata
);

  localparam logic [2:0] CMD_READ                   = 3'd1;
  localparam logic [2:0] CMD_WRITE                  = 3'd2;
  localparam logic [2:0] RESPONSE_SUCCESS           = 3'd0;
  localparam logic [2:0] RESPONSE_UNKNOWN_ADDRESS   = 3'd1;
  localparam logic [2:0] RESPONSE_INVALID_OPERATION = 3'd2;

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT,
    ST_GAP
  } state_t;

  // Storage has no reset: contents survive rst_n and are preloaded by benches.
  logic [31:0] mem [0:WORDS-1];

  state_t                state;
  state_t                state_d;
  logic [2:0]            cmd_q;
  logic [DEPTH_LOG2-1:0] base_q;
  logic [3:0]            beats_q;
  logic [3:0]            beat_idx;
  logic [3:0]            beat_idx_d;
  logic [4:0]            wait_cnt;
  logic [4:0]            wait_d;
  logic [2:0]            resp_q;

  // Request decode, used only at latch time.
  logic [DEPTH_LOG2-1:0] base_in;
  logic [3:0]            beats_in;
  logic [2:0]            resp_in;
  logic [4:0]            init_wait;

  // Per-cycle control produced by the FSM.
  logic                  latch;
  logic                  enter_beat;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [2:0]            resp_beat;
  logic                  read_beat;

  assign base_in  = address[DEPTH_LOG2+1:2];
  assign beats_in = (burstcount == 4'd0) ? 4'd1 : burstcount;

  always_comb begin
    resp_in = RESPONSE_SUCCESS;
    if ((cmd != CMD_READ) && (cmd != CMD_WRITE)) begin
      resp_in = RESPONSE_INVALID_OPERATION;
    end else if (address[1:0] != 2'b00) begin
      resp_in = RESPONSE_INVALID_OPERATION;
    end else if (address[33:DEPTH_LOG2+2] != '0) begin
      resp_in = RESPONSE_UNKNOWN_ADDRESS;
    end
  end

`ifdef ARMLEOBUS_RESP_JITTER_EN
  logic [15:0] lfsr;

  // Right-shifting Galois form; mask 16'hB400 realises taps 16,14,13,11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign init_wait = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
`else
  assign init_wait = 5'(WAIT_CYCLES);
`endif

  // Word index of the beat being closed; wraps at the top of memory.
  assign wr_idx = base_q + {{(DEPTH_LOG2-4){1'b0}}, beat_idx};

  always_comb begin
    state_d    = state;
    beat_idx_d = beat_idx;
    wait_d     = wait_cnt;
    latch      = 1'b0;
    enter_beat = 1'b0;
    mem_we     = 1'b0;
    rd_idx     = wr_idx;
    resp_beat  = resp_q;
    read_beat  = (cmd_q == CMD_READ);

    case (state)
      ST_IDLE: begin
        if (transaction) begin
          latch      = 1'b1;
          beat_idx_d = 4'd0;
          if (init_wait == 5'd0) begin
            // No wait states: beat 0's outputs come straight from the request.
            state_d    = ST_BEAT;
            enter_beat = 1'b1;
            rd_idx     = base_in;
            resp_beat  = resp_in;
            read_beat  = (cmd == CMD_READ);
          end else begin
            wait_d  = init_wait - 5'd1;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!transaction) begin
          state_d = ST_GAP;
          wait_d  = 5'd0;
        end else if (wait_cnt == 5'd0) begin
          // beat_idx is 0 here, so the default rd_idx already points at beat 0.
          state_d    = ST_BEAT;
          enter_beat = 1'b1;
        end else begin
          wait_d = wait_cnt - 5'd1;
        end
      end

      ST_BEAT: begin
        if (!transaction) begin
          // Initiator dropped the request mid-burst: abandon without writing.
          state_d    = ST_GAP;
          beat_idx_d = 4'd0;
        end else begin
          mem_we = (cmd_q == CMD_WRITE) && (resp_q == RESPONSE_SUCCESS);
          if (beat_idx == beats_q - 4'd1) begin
            state_d    = ST_GAP;
            beat_idx_d = 4'd0;
          end else begin
            beat_idx_d = beat_idx + 4'd1;
            enter_beat = 1'b1;
            rd_idx     = base_q + {{(DEPTH_LOG2-4){1'b0}}, beat_idx + 4'd1};
          end
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_idx <= 4'd0;
      wait_cnt <= 5'd0;
      cmd_q    <= 3'd0;
      base_q   <= '0;
      beats_q  <= 4'd1;
      resp_q   <= RESPONSE_SUCCESS;
    end else begin
      state    <= state_d;
      beat_idx <= beat_idx_d;
      wait_cnt <= wait_d;
      if (latch) begin
        cmd_q   <= cmd;
        base_q  <= base_in;
        beats_q <= beats_in;
        resp_q  <= resp_in;
      end
    end
  end

  // Outputs are registered so they are stable for the whole BEAT cycle;
  // they are loaded on the edge that enters each beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      transaction_done     <= 1'b0;
      transaction_response <= RESPONSE_SUCCESS;
      rdata                <= 32'd0;
    end else begin
      transaction_done     <= enter_beat;
      transaction_response <= enter_beat ? resp_beat : RESPONSE_SUCCESS;
      if (enter_beat && read_beat && (resp_beat == RESPONSE_SUCCESS)) begin
        rdata <= mem[rd_idx];
      end else begin
        rdata <= 32'd0;
      end
    end
  end

  // Write data is taken on the edge that closes the beat, so the initiator
  // may advance wdata right after it observes transaction_done.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbyte_enable[b]) begin
          mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_armleobus_wait_responder.sv
// tb/tb_armleobus_wait_responder.sv - directed self-checking bench for armleobus_wait_responder

module tb_armleobus_wait_responder;

  localparam int W  = 2;
  localparam int DL = 16;

  localparam logic [2:0] C_READ  = 3'd1;
  localparam logic [2:0] C_WRITE = 3'd2;
  localparam logic [2:0] R_OK    = 3'd0;
  localparam logic [2:0] R_UNK   = 3'd1;
  localparam logic [2:0] R_INV   = 3'd2;

  logic        clk;
  logic        rst_n;
  logic        transaction;
  logic [2:0]  cmd;
  logic [33:0] address;
  logic [3:0]  burstcount;
  logic [31:0] wdata;
  logic [3:0]  wbyte_enable;
  logic        transaction_done;
  logic [2:0]  transaction_response;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] obs_rdata [0:15];
  logic [2:0]  obs_resp  [0:15];
  int          obs_step  [0:15];
  int          obs_n;
  int          obs_lat;
  logic        obs_gap_done;

  armleobus_wait_responder #(
    .DEPTH_LOG2  (DL),
    .WAIT_CYCLES (W)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .transaction          (transaction),
    .cmd                  (cmd),
    .address              (address),
    .burstcount           (burstcount),
    .wdata                (wdata),
    .wbyte_enable         (wbyte_enable),
    .transaction_done     (transaction_done),
    .transaction_response (transaction_response),
    .rdata                (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int lat);
`ifdef ARMLEOBUS_RESP_JITTER_EN
    chk(tag, 64'((lat >= W + 1) && (lat <= W + 4)), 64'd1);
`else
    chk(tag, 64'(lat), 64'(W + 1));
`endif
  endtask

  // Runs one full transaction and leaves the responder back in IDLE.
  // Beat k carries wdata = wb + k.
  task automatic do_txn(input logic [2:0] c, input logic [33:0] a, input logic [3:0] bc,
                        input logic [3:0] be, input logic [31:0] wb);
    int beats;
    int steps;
    beats   = (bc == 4'd0) ? 1 : int'(bc);
    steps   = 0;
    obs_n   = 0;
    obs_lat = 0;
    cmd          = c;
    address      = a;
    burstcount   = bc;
    wbyte_enable = be;
    wdata        = wb;
    transaction  = 1'b1;
    while (obs_n < beats && steps < 60) begin
      @(posedge clk);
      #1;
      steps++;
      wdata = wb + 32'(obs_n);
      if (transaction_done) begin
        if (obs_n == 0) obs_lat = steps;
        obs_rdata[obs_n] = rdata;
        obs_resp[obs_n]  = transaction_response;
        obs_step[obs_n]  = steps;
        obs_n++;
      end
    end
    if (steps >= 60) chk("txn_timeout", 64'(obs_n), 64'(beats));
    @(posedge clk);
    #1;
    obs_gap_done = transaction_done;
    transaction  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int dones;
  int guard;

  initial begin
    rst_n        = 1'b0;
    transaction  = 1'b0;
    cmd          = 3'd0;
    address      = 34'd0;
    burstcount   = 4'd0;
    wdata        = 32'd0;
    wbyte_enable = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 64'(transaction_done), 64'd0);
    chk("rst_resp", 64'(transaction_response), 64'(R_OK));
    chk("rst_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word write then read back.
    do_txn(C_WRITE, 34'h0_0000_1004, 4'd1, 4'hF, 32'h0000_0001);
    chk("wr1_resp", 64'(obs_resp[0]), 64'(R_OK));
    chk_lat("wr1_lat", obs_lat);
    do_txn(C_READ, 34'h0_0000_1004, 4'd1, 4'hF, 32'd0);
    chk("rd1_resp", 64'(obs_resp[0]), 64'(R_OK));
    chk("rd1_data", 64'(obs_rdata[0]), 64'h1);
    chk_lat("rd1_lat", obs_lat);

    // Single-byte write merges into the existing word.
    dut.mem[16] = 32'h1122_3344;
    do_txn(C_WRITE, 34'h0_0000_0040, 4'd1, 4'b0100, 32'h00AB_0000);
    do_txn(C_READ, 34'h0_0000_0040, 4'd1, 4'hF, 32'd0);
    chk("byte_merge", 64'(obs_rdata[0]), 64'h11AB_3344);

    // Four-beat read burst, consecutive pulses, then a quiet gap cycle.
    for (int i = 0; i < 4; i++) dut.mem[64 + i] = 32'(10 + i);
    do_txn(C_READ, 34'h0_0000_0100, 4'd4, 4'hF, 32'd0);
    chk("burst_n", 64'(obs_n), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_data%0d", i), 64'(obs_rdata[i]), 64'(10 + i));
      chk($sformatf("burst_step%0d", i), 64'(obs_step[i] - obs_step[0]), 64'(i));
    end
    chk("burst_gap", 64'(obs_gap_done), 64'd0);

    // burstcount of 0 behaves as a single beat.
    do_txn(C_READ, 34'h0_0000_0104, 4'd0, 4'hF, 32'd0);
    chk("bc0_n", 64'(obs_n), 64'd1);
    chk("bc0_data", 64'(obs_rdata[0]), 64'd11);
    chk("bc0_gap", 64'(obs_gap_done), 64'd0);

    // Error responses.
    dut.mem[0] = 32'hCAFE_F00D;
    do_txn(C_READ, 34'h1_0000_0000, 4'd1, 4'hF, 32'd0);
    chk("unk_resp", 64'(obs_resp[0]), 64'(R_UNK));
    chk("unk_rdata", 64'(obs_rdata[0]), 64'd0);
    do_txn(C_READ, 34'h0_0004_0000, 4'd1, 4'hF, 32'd0);
    chk("unk_edge_resp", 64'(obs_resp[0]), 64'(R_UNK));
    do_txn(C_WRITE, 34'h0_0000_0002, 4'd1, 4'hF, 32'hFFFF_FFFF);
    chk("mis_resp", 64'(obs_resp[0]), 64'(R_INV));
    do_txn(C_READ, 34'h0_0000_0000, 4'd1, 4'hF, 32'd0);
    chk("mis_nowrite", 64'(obs_rdata[0]), 64'hCAFE_F00D);
    do_txn(3'b111, 34'h0_0000_0008, 4'd1, 4'hF, 32'd0);
    chk("badcmd_resp", 64'(obs_resp[0]), 64'(R_INV));
    do_txn(3'b111, 34'h1_0000_0003, 4'd1, 4'hF, 32'd0);
    chk("prio_resp", 64'(obs_resp[0]), 64'(R_INV));
    do_txn(C_READ, 34'h1_0000_0001, 4'd1, 4'hF, 32'd0);
    chk("prio2_resp", 64'(obs_resp[0]), 64'(R_INV));

    // Last word is in range; a burst from there wraps to word 0.
    dut.mem[65535] = 32'h0000_00AA;
    do_txn(C_READ, 34'h0_0003_FFFC, 4'd2, 4'hF, 32'd0);
    chk("wrap_resp0", 64'(obs_resp[0]), 64'(R_OK));
    chk("wrap_data0", 64'(obs_rdata[0]), 64'hAA);
    chk("wrap_resp1", 64'(obs_resp[1]), 64'(R_OK));
    chk("wrap_data1", 64'(obs_rdata[1]), 64'hCAFE_F00D);

    // Abort: drop the request during beat 1 of a 4-beat write.
    for (int i = 0; i < 4; i++) dut.mem[128 + i] = 32'd0;
    cmd          = C_WRITE;
    address      = 34'h0_0000_0200;
    burstcount   = 4'd4;
    wbyte_enable = 4'hF;
    wdata        = 32'h0000_5000;
    transaction  = 1'b1;
    guard        = 0;
    while (!transaction_done && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("abort_beat0_seen", 64'(transaction_done), 64'd1);
    @(posedge clk);
    #1;
    wdata       = 32'h0000_5001;
    transaction = 1'b0;
    dones       = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (transaction_done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    do_txn(C_READ, 34'h0_0000_0200, 4'd4, 4'hF, 32'd0);
    chk("abort_w0", 64'(obs_rdata[0]), 64'h5000);
    chk("abort_w1", 64'(obs_rdata[1]), 64'h0);
    chk("abort_w2", 64'(obs_rdata[2]), 64'h0);

    // Reset during WAIT: outputs go to reset values without a clock edge.
    cmd         = C_READ;
    address     = 34'h0_0000_1004;
    burstcount  = 4'd1;
    transaction = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_done", 64'(transaction_done), 64'd0);
    chk("rstw_resp", 64'(transaction_response), 64'(R_OK));
    chk("rstw_rdata", 64'(rdata), 64'd0);
    transaction = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during BEAT while a read is presenting data.
    @(posedge clk);
    #1;
    transaction = 1'b1;
    guard       = 0;
    while (!transaction_done && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("rstb_pre_rdata", 64'(rdata), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rstb_done", 64'(transaction_done), 64'd0);
    chk("rstb_rdata", 64'(rdata), 64'd0);
    transaction = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Memory survives reset and timing restarts cleanly.
    do_txn(C_READ, 34'h0_0000_1004, 4'd1, 4'hF, 32'd0);
    chk("post_rst_data", 64'(obs_rdata[0]), 64'h1);
    chk_lat("post_rst_lat", obs_lat);

`ifdef ARMLEOBUS_RESP_JITTER_EN
    for (int i = 0; i < 256; i++) dut.mem[2048 + i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    for (int n = 0; n < 100; n++) begin
      int idx;
      idx = int'($urandom_range(0, 255));
      do_txn(C_READ, 34'h0_0000_2000 + 34'(idx * 4), 4'd1, 4'hF, 32'd0);
      chk("jit_data", 64'(obs_rdata[0]), 64'((32'(idx) * 32'h0101_0101) ^ 32'h5A5A_0000));
      chk_lat("jit_lat", obs_lat);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
